// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program counter width, reset address and
// the next-PC source encoding used by the fetch path.
package cpu_pkg;

    localparam int PC_WIDTH = 8;
    localparam logic [PC_WIDTH-1:0] PC_RESET = 8'h00;

    typedef enum logic {
        PC_SEL_INC = 1'b0,
        PC_SEL_BUS = 1'b1
    } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential fetch (PC+1, wrapping) or
// a jump/branch target taken from the C bus.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    input  pc_sel_e          sel,
    input  logic [WIDTH-1:0] bus_data,
    output logic [WIDTH-1:0] next_pc
);

    always_comb begin
        next_pc = pc + WIDTH'(1);
        case (sel)
            PC_SEL_INC: next_pc = pc + WIDTH'(1);
            PC_SEL_BUS: next_pc = bus_data;
            default:    next_pc = pc + WIDTH'(1);
        endcase
    end

endmodule

// File: rtl/pc_n_mux.sv
// Program counter register with reset/enable priority; the fetch address
// comes straight from the register so no input reaches addr_PC combinationally.
module pc_n_mux
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
    input  logic             clk_pc,
    input  logic             rstn_pc,
    input  logic             write_pc,
    input  logic             PC_sel,
    input  logic [WIDTH-1:0] cBusData,
    output logic [WIDTH-1:0] addr_PC
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] next_pc;

    pc_next_mux #(
        .WIDTH(WIDTH)
    ) u_next_mux (
        .pc      (pc_q),
        .sel     (pc_sel_e'(PC_sel)),
        .bus_data(cBusData),
        .next_pc (next_pc)
    );

    // Reset dominates the enable, so a held reset ignores PC_sel/cBusData.
    always_ff @(posedge clk_pc) begin
        if (!rstn_pc) begin
            pc_q <= RESET_VALUE;
        end else if (write_pc) begin
            pc_q <= next_pc;
        end
    end

    assign addr_PC = pc_q;

endmodule

// File: tb/tb_pc_n_mux.sv
// Directed plus randomised checks of the program counter: reset, counting,
// wrap, reset mid-count, bus loads and write-enable hold.
module tb_pc_n_mux;

    localparam int W = 8;

    logic         clk_pc;
    logic         rstn_pc;
    logic         write_pc;
    logic         PC_sel;
    logic [W-1:0] cBusData;
    logic [W-1:0] addr_PC;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_pc;
    int           n_checks;
    int           n_fail;

    pc_n_mux #(
        .WIDTH      (W),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk_pc  (clk_pc),
        .rstn_pc (rstn_pc),
        .write_pc(write_pc),
        .PC_sel  (PC_sel),
        .cBusData(cBusData),
        .addr_PC (addr_PC)
    );

    // clock / reset block
    initial begin
        clk_pc = 1'b0;
        forever #5 clk_pc = ~clk_pc;
    end

    initial begin
        rstn_pc  = 1'b0;
        write_pc = 1'b0;
        PC_sel   = 1'b0;
        cBusData = '0;
        model_pc = '0;
    end

    // Drive one cycle of inputs, push the expected PC, then compare after the edge.
    task automatic step(input string tag, input logic rstn, input logic wr,
                        input logic sel, input logic [W-1:0] bus);
        logic [W-1:0] exp_v;
        @(negedge clk_pc);
        rstn_pc  = rstn;
        write_pc = wr;
        PC_sel   = sel;
        cBusData = bus;
        if (!rstn)
            model_pc = 8'h00;
        else if (wr)
            model_pc = sel ? bus : W'(model_pc + 8'd1);
        exp_q.push_back(model_pc);
        @(posedge clk_pc);
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        assert (addr_PC === exp_v) else begin
            n_fail++;
            $error("FAIL %s: addr_PC=%02h expected=%02h", tag, addr_PC, exp_v);
        end
    endtask

    task automatic check_const(input string tag, input logic [W-1:0] exp_v);
        n_checks++;
        assert (addr_PC === exp_v) else begin
            n_fail++;
            $error("FAIL %s: addr_PC=%02h expected=%02h", tag, addr_PC, exp_v);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // reset with increment selected and a live bus value
        step("reset", 1'b0, 1'b1, 1'b0, 8'd101);
        check_const("reset_const", 8'h00);
        step("reset_hold", 1'b0, 1'b1, 1'b1, 8'd77);

        // count up from reset
        for (int i = 0; i < 11; i++) step("count", 1'b1, 1'b1, 1'b0, 8'd101);
        check_const("count_11", 8'd11);

        // reset mid-count, bus select ignored while held
        step("rst_mid", 1'b0, 1'b1, 1'b0, 8'd101);
        check_const("rst_mid_const", 8'h00);
        for (int i = 0; i < 3; i++)
            step("rst_mid_hold", 1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
        check_const("rst_mid_hold_const", 8'h00);

        // bus load and reload
        step("load", 1'b1, 1'b1, 1'b1, 8'd101);
        check_const("load_const", 8'h65);
        step("load_hold", 1'b1, 1'b1, 1'b1, 8'd101);
        step("load_hold", 1'b1, 1'b1, 1'b1, 8'd101);
        step("load_new", 1'b1, 1'b1, 1'b1, 8'h20);
        check_const("load_new_const", 8'h20);

        // hold with write disabled at PC=5
        step("rst_for_hold", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step("inc_to_5", 1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            step("hold", 1'b1, 1'b0, 1'(i % 2), 8'($urandom_range(0, 255)));
        check_const("hold_const", 8'd5);
        step("hold_release", 1'b1, 1'b1, 1'b0, 8'hC3);
        check_const("hold_release_const", 8'd6);

        // full wrap: 256 increments from 0 land back on 0
        step("rst_for_wrap", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 255; i++) step("wrap", 1'b1, 1'b1, 1'b0, 8'h00);
        check_const("wrap_ff", 8'hFF);
        step("wrap_edge", 1'b1, 1'b1, 1'b0, 8'h00);
        check_const("wrap_zero", 8'h00);

        // randomised mix of all controls
        for (int i = 0; i < 40; i++)
            step("random", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

        n_checks++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL queue_empty: size=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
